// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the L1I/L1D-to-L2 cache arbiter.
// ADDR_W and LINE_W are shared with the L1 and L2 caches.
package cache_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: round-robin grant between I and D with no preemption.
// Emits one-cycle grant and clear strobes for the capture registers in the top.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   l2_resp,
  output state_t state,
  output logic   grant_i_c,
  output logic   grant_d_c,
  output logic   clear_c
);

  state_t state_d;
  grant_t last_grant;
  grant_t last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
    end
  end

  // On a tie, the side that did not win last time gets the grant
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    grant_i_c    = 1'b0;
    grant_d_c    = 1'b0;
    clear_c      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (last_grant == GRANT_D))) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          grant_i_c    = 1'b1;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          grant_d_c    = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d = IDLE;
          clear_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port arbiter serialising L1I reads and L1D reads/writebacks onto one L2 port.
// Holds the downstream capture registers and routes responses back to the owner.
module cache_arbiter #(
  parameter int unsigned ADDR_W = cache_arbiter_pkg::ADDR_W,
  parameter int unsigned LINE_W = cache_arbiter_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] l1i_arbi_address,
  input  logic              l1i_arbi_read,
  output logic [LINE_W-1:0] l1i_arbi_rdata,
  output logic              l1i_arbi_resp,
  input  logic [ADDR_W-1:0] l1d_arbi_address,
  input  logic              l1d_arbi_read,
  input  logic              l1d_arbi_write,
  input  logic [LINE_W-1:0] l1d_arbi_wdata,
  output logic [LINE_W-1:0] l1d_arbi_rdata,
  output logic              l1d_arbi_resp,
  output logic [ADDR_W-1:0] arbi_l2_address,
  output logic              arbi_l2_read,
  output logic              arbi_l2_write,
  output logic [LINE_W-1:0] arbi_l2_wdata,
  input  logic [LINE_W-1:0] arbi_l2_rdata,
  input  logic              arbi_l2_resp
);

  cache_arbiter_pkg::state_t state;
  logic d_req;
  logic grant_i_c;
  logic grant_d_c;
  logic clear_c;

  assign d_req = l1d_arbi_read | l1d_arbi_write;

  cache_arbiter_control u_control (
    .clk       (clk),
    .rst       (rst),
    .i_req     (l1i_arbi_read),
    .d_req     (d_req),
    .l2_resp   (arbi_l2_resp),
    .state     (state),
    .grant_i_c (grant_i_c),
    .grant_d_c (grant_d_c),
    .clear_c   (clear_c)
  );

  // Downstream request registers; a D request with both strobes high is a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arbi_l2_address <= '0;
      arbi_l2_read    <= 1'b0;
      arbi_l2_write   <= 1'b0;
      arbi_l2_wdata   <= '0;
    end else if (grant_i_c) begin
      arbi_l2_address <= l1i_arbi_address;
      arbi_l2_read    <= 1'b1;
      arbi_l2_write   <= 1'b0;
    end else if (grant_d_c) begin
      arbi_l2_address <= l1d_arbi_address;
      arbi_l2_read    <= l1d_arbi_read & ~l1d_arbi_write;
      arbi_l2_write   <= l1d_arbi_write;
      arbi_l2_wdata   <= l1d_arbi_wdata;
    end else if (clear_c) begin
      arbi_l2_read    <= 1'b0;
      arbi_l2_write   <= 1'b0;
    end
  end

  // Zero-latency response path; only the current owner sees resp
  assign l1i_arbi_resp  = arbi_l2_resp && (state == cache_arbiter_pkg::SERVE_I);
  assign l1d_arbi_resp  = arbi_l2_resp && (state == cache_arbiter_pkg::SERVE_D);
  assign l1i_arbi_rdata = arbi_l2_rdata;
  assign l1d_arbi_rdata = arbi_l2_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter against a transaction-level model.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] l1i_arbi_address;
  logic          l1i_arbi_read;
  logic [LW-1:0] l1i_arbi_rdata;
  logic          l1i_arbi_resp;
  logic [AW-1:0] l1d_arbi_address;
  logic          l1d_arbi_read;
  logic          l1d_arbi_write;
  logic [LW-1:0] l1d_arbi_wdata;
  logic [LW-1:0] l1d_arbi_rdata;
  logic          l1d_arbi_resp;
  logic [AW-1:0] arbi_l2_address;
  logic          arbi_l2_read;
  logic          arbi_l2_write;
  logic [LW-1:0] arbi_l2_wdata;
  logic [LW-1:0] arbi_l2_rdata;
  logic          arbi_l2_resp;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0 = none, 1 = I, 2 = D; last winner 1 = I, 2 = D
  int            m_owner;
  int            m_last;
  logic [AW-1:0] m_addr;
  logic          m_rd;
  logic          m_wr;
  logic [LW-1:0] m_wdata;

  int   i_resp_cnt;
  int   d_resp_cnt;
  int   proto_viol;
  logic saw_i;
  logic saw_d;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .l1i_arbi_address (l1i_arbi_address),
    .l1i_arbi_read    (l1i_arbi_read),
    .l1i_arbi_rdata   (l1i_arbi_rdata),
    .l1i_arbi_resp    (l1i_arbi_resp),
    .l1d_arbi_address (l1d_arbi_address),
    .l1d_arbi_read    (l1d_arbi_read),
    .l1d_arbi_write   (l1d_arbi_write),
    .l1d_arbi_wdata   (l1d_arbi_wdata),
    .l1d_arbi_rdata   (l1d_arbi_rdata),
    .l1d_arbi_resp    (l1d_arbi_resp),
    .arbi_l2_address  (arbi_l2_address),
    .arbi_l2_read     (arbi_l2_read),
    .arbi_l2_write    (arbi_l2_write),
    .arbi_l2_wdata    (arbi_l2_wdata),
    .arbi_l2_rdata    (arbi_l2_rdata),
    .arbi_l2_resp     (arbi_l2_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_addr  = '0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_wdata = '0;
  endtask

  // Called just after a rising edge with this cycle's inputs applied
  task automatic settle();
    logic exp_i;
    logic exp_d;
    if (rst) model_reset();
    #1;
    exp_i = !rst && arbi_l2_resp && (m_owner == 1);
    exp_d = !rst && arbi_l2_resp && (m_owner == 2);
    chk("l2_read",  LW'(arbi_l2_read),    LW'(m_rd));
    chk("l2_write", LW'(arbi_l2_write),   LW'(m_wr));
    chk("l2_addr",  LW'(arbi_l2_address), LW'(m_addr));
    chk("l2_wdata", arbi_l2_wdata,        m_wdata);
    chk("i_resp",   LW'(l1i_arbi_resp),   LW'(exp_i));
    chk("d_resp",   LW'(l1d_arbi_resp),   LW'(exp_d));
    chk("i_rdata",  l1i_arbi_rdata,       arbi_l2_rdata);
    chk("d_rdata",  l1d_arbi_rdata,       arbi_l2_rdata);
    if (l1d_arbi_read && l1d_arbi_write) proto_viol++;
    saw_i = l1i_arbi_resp;
    saw_d = l1d_arbi_resp;
    if (saw_i) i_resp_cnt++;
    if (saw_d) d_resp_cnt++;
  endtask

  // Apply the arbitration rules to the inputs held across the coming edge
  task automatic advance();
    int  win;
    logic pi;
    logic pd;
    if (!rst) begin
      if (m_owner == 0) begin
        pi  = l1i_arbi_read;
        pd  = l1d_arbi_read | l1d_arbi_write;
        win = 0;
        if (pi && pd) win = (m_last == 1) ? 2 : 1;
        else if (pi)  win = 1;
        else if (pd)  win = 2;
        if (win == 1) begin
          m_owner = 1;
          m_last  = 1;
          m_addr  = l1i_arbi_address;
          m_rd    = 1'b1;
          m_wr    = 1'b0;
        end else if (win == 2) begin
          m_owner = 2;
          m_last  = 2;
          m_addr  = l1d_arbi_address;
          m_wr    = l1d_arbi_write;
          m_rd    = l1d_arbi_read && !l1d_arbi_write;
          m_wdata = l1d_arbi_wdata;
        end
      end else if (arbi_l2_resp) begin
        m_owner = 0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    int   l2_wait;
    logic i_cool;
    logic d_cool;

    rst              = 1'b1;
    l1i_arbi_address = '0;
    l1i_arbi_read    = 1'b0;
    l1d_arbi_address = '0;
    l1d_arbi_read    = 1'b0;
    l1d_arbi_write   = 1'b0;
    l1d_arbi_wdata   = '0;
    arbi_l2_rdata    = {8{$urandom}};
    arbi_l2_resp     = 1'b0;
    i_resp_cnt       = 0;
    d_resp_cnt       = 0;
    proto_viol       = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    settle();
    chk("rst_read",  LW'(arbi_l2_read),    LW'(1'b0));
    chk("rst_write", LW'(arbi_l2_write),   LW'(1'b0));
    chk("rst_addr",  LW'(arbi_l2_address), LW'(32'h0));
    chk("rst_wdata", arbi_l2_wdata,        LW'(0));
    advance();
    rst = 1'b0;
    step();

    // I read alone, address changed mid-service, L2 resp after 5 cycles
    i_resp_cnt = 0;
    d_resp_cnt = 0;
    l1i_arbi_address = 32'h0000_1000;
    l1i_arbi_read    = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) l1i_arbi_address = 32'h0000_1FC0;
      if (k == 6) arbi_l2_resp = 1'b1;
      settle();
      chk("t1_read", LW'(arbi_l2_read),    LW'(1'b1));
      chk("t1_addr", LW'(arbi_l2_address), LW'(32'h0000_1000));
      if (k == 6) chk("t1_iresp", LW'(l1i_arbi_resp), LW'(1'b1));
      advance();
    end
    l1i_arbi_read = 1'b0;
    arbi_l2_resp  = 1'b0;
    settle();
    chk("t1_idle_read", LW'(arbi_l2_read), LW'(1'b0));
    chk("t1_icount",    LW'(i_resp_cnt),   LW'(1));
    chk("t1_dcount",    LW'(d_resp_cnt),   LW'(0));
    advance();

    // D writeback
    l1d_arbi_address = 32'h0000_2000;
    l1d_arbi_write   = 1'b1;
    l1d_arbi_wdata   = {32{8'hA5}};
    step();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) arbi_l2_resp = 1'b1;
      settle();
      chk("t2_write", LW'(arbi_l2_write), LW'(1'b1));
      chk("t2_read",  LW'(arbi_l2_read),  LW'(1'b0));
      chk("t2_wdata", arbi_l2_wdata,      {32{8'hA5}});
      if (k == 3) chk("t2_dresp", LW'(l1d_arbi_resp), LW'(1'b1));
      advance();
    end
    l1d_arbi_write = 1'b0;
    arbi_l2_resp   = 1'b0;
    step();

    // Tie right after reset goes to D, then I two cycles after D's resp
    rst = 1'b1;
    step();
    rst = 1'b0;
    l1i_arbi_address = 32'h0000_3100;
    l1i_arbi_read    = 1'b1;
    l1d_arbi_address = 32'h0000_3200;
    l1d_arbi_read    = 1'b1;
    step();
    settle();
    chk("t3_first_addr", LW'(arbi_l2_address), LW'(32'h0000_3200));
    advance();
    arbi_l2_resp = 1'b1;
    settle();
    chk("t3_dresp", LW'(l1d_arbi_resp), LW'(1'b1));
    advance();
    arbi_l2_resp  = 1'b0;
    l1d_arbi_read = 1'b0;
    settle();
    chk("t3_gap_read", LW'(arbi_l2_read), LW'(1'b0));
    advance();
    arbi_l2_resp = 1'b1;
    settle();
    chk("t3_i_read", LW'(arbi_l2_read),    LW'(1'b1));
    chk("t3_i_addr", LW'(arbi_l2_address), LW'(32'h0000_3100));
    chk("t3_iresp",  LW'(l1i_arbi_resp),   LW'(1'b1));
    advance();
    arbi_l2_resp  = 1'b0;
    l1i_arbi_read = 1'b0;
    step();
    l1i_arbi_address = 32'h0000_3300;
    l1i_arbi_read    = 1'b1;
    l1d_arbi_address = 32'h0000_3400;
    l1d_arbi_read    = 1'b1;
    step();
    settle();
    chk("t3_tie2_addr", LW'(arbi_l2_address), LW'(32'h0000_3400));
    advance();
    l1i_arbi_read = 1'b0;
    arbi_l2_resp  = 1'b1;
    step();
    l1d_arbi_read = 1'b0;
    arbi_l2_resp  = 1'b0;
    step();

    // Reset during SERVE_D, late L2 resp, then a tie goes to D
    l1d_arbi_address = 32'h0000_5000;
    l1d_arbi_read    = 1'b1;
    step();
    settle();
    chk("t4_serving", LW'(arbi_l2_read), LW'(1'b1));
    advance();
    rst = 1'b1;
    settle();
    chk("t4_rst_read", LW'(arbi_l2_read),    LW'(1'b0));
    chk("t4_rst_addr", LW'(arbi_l2_address), LW'(32'h0));
    advance();
    rst              = 1'b0;
    arbi_l2_resp     = 1'b1;
    l1i_arbi_address = 32'h0000_5100;
    l1i_arbi_read    = 1'b1;
    settle();
    chk("t4_late_dresp", LW'(l1d_arbi_resp), LW'(1'b0));
    advance();
    arbi_l2_resp = 1'b0;
    settle();
    chk("t4_tie_addr", LW'(arbi_l2_address), LW'(32'h0000_5000));
    advance();
    l1i_arbi_read = 1'b0;
    arbi_l2_resp  = 1'b1;
    step();
    l1d_arbi_read = 1'b0;
    arbi_l2_resp  = 1'b0;
    step();

    // L2 resp while idle is ignored
    arbi_l2_resp = 1'b1;
    settle();
    chk("t5_iresp", LW'(l1i_arbi_resp), LW'(1'b0));
    chk("t5_dresp", LW'(l1d_arbi_resp), LW'(1'b0));
    advance();
    arbi_l2_resp = 1'b0;
    settle();
    chk("t5_still_idle", LW'({arbi_l2_read, arbi_l2_write}), LW'(2'b00));
    advance();

    // D read and write together: write wins, flagged as a protocol violation
    proto_viol       = 0;
    l1d_arbi_address = 32'h0000_6000;
    l1d_arbi_read    = 1'b1;
    l1d_arbi_write   = 1'b1;
    l1d_arbi_wdata   = {8{32'hDEAD_BEEF}};
    step();
    settle();
    chk("t6_write", LW'(arbi_l2_write), LW'(1'b1));
    chk("t6_read",  LW'(arbi_l2_read),  LW'(1'b0));
    chk("t6_proto_flag", LW'(proto_viol != 0), LW'(1'b1));
    advance();
    arbi_l2_resp = 1'b1;
    step();
    l1d_arbi_read  = 1'b0;
    l1d_arbi_write = 1'b0;
    arbi_l2_resp   = 1'b0;
    step();

    // Randomized traffic
    l2_wait = -1;
    i_cool  = 1'b0;
    d_cool  = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;

      if (rst) begin
        l1i_arbi_read  = 1'b0;
        l1d_arbi_read  = 1'b0;
        l1d_arbi_write = 1'b0;
        i_cool  = 1'b0;
        d_cool  = 1'b0;
        l2_wait = -1;
      end else begin
        if (i_cool) begin
          l1i_arbi_read = 1'b0;
          i_cool = 1'b0;
        end else if (!l1i_arbi_read) begin
          if ($urandom_range(0, 3) == 0) begin
            l1i_arbi_read    = 1'b1;
            l1i_arbi_address = $urandom & 32'hFFFF_FFE0;
          end
        end else begin
          if ($urandom_range(0, 7) == 0)  l1i_arbi_address = $urandom & 32'hFFFF_FFE0;
          if ($urandom_range(0, 31) == 0) l1i_arbi_read = 1'b0;
        end

        if (d_cool) begin
          l1d_arbi_read  = 1'b0;
          l1d_arbi_write = 1'b0;
          d_cool = 1'b0;
        end else if (!(l1d_arbi_read || l1d_arbi_write)) begin
          if ($urandom_range(0, 3) == 0) begin
            l1d_arbi_write   = ($urandom_range(0, 1) == 1);
            l1d_arbi_read    = !l1d_arbi_write;
            l1d_arbi_address = $urandom & 32'hFFFF_FFE0;
            l1d_arbi_wdata   = {8{$urandom}};
          end
        end else begin
          if ($urandom_range(0, 7) == 0) begin
            l1d_arbi_address = $urandom & 32'hFFFF_FFE0;
            l1d_arbi_wdata   = {8{$urandom}};
          end
          if ($urandom_range(0, 31) == 0) begin
            l1d_arbi_read  = 1'b0;
            l1d_arbi_write = 1'b0;
          end
        end
      end

      arbi_l2_resp  = 1'b0;
      arbi_l2_rdata = {8{$urandom}};
      if (arbi_l2_read || arbi_l2_write) begin
        if (l2_wait < 0) l2_wait = $urandom_range(0, 4);
        if (l2_wait == 0) begin
          arbi_l2_resp = 1'b1;
          l2_wait = -1;
        end else begin
          l2_wait--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        arbi_l2_resp = 1'b1;
      end

      settle();
      advance();
      if (saw_i) i_cool = 1'b1;
      if (saw_d) d_cool = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter between the split L1 caches and the single L2/memory port. Accepts line-sized (256-bit) read requests from L1Icache and read/write requests from L1Dcache, serialises them onto one downstream port, and routes each response back to the requester. Uses round-robin on simultaneous requests and never preempts a transaction in flight. Sits directly downstream of both L1 caches, upstream of L2.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cache line width

Ports (reset is asynchronous, active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- l1i_arbi_address  in  ADDR_W  I-cache line address
- l1i_arbi_read  in  1  I-cache read request (held until resp)
- l1i_arbi_rdata  out  LINE_W  line returned to I-cache
- l1i_arbi_resp  out  1  I-cache transaction complete, 1-cycle pulse
- l1d_arbi_address  in  ADDR_W  D-cache line address
- l1d_arbi_read  in  1  D-cache read request
- l1d_arbi_write  in  1  D-cache writeback request
- l1d_arbi_wdata  in  LINE_W  writeback line
- l1d_arbi_rdata  out  LINE_W  line returned to D-cache
- l1d_arbi_resp  out  1  D-cache transaction complete, 1-cycle pulse
- arbi_l2_address  out  ADDR_W  downstream address (registered)
- arbi_l2_read  out  1  downstream read (registered)
- arbi_l2_write  out  1  downstream write (registered)
- arbi_l2_wdata  out  LINE_W  downstream write line (registered)
- arbi_l2_rdata  in  LINE_W  downstream read line
- arbi_l2_resp  in  1  downstream transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset state IDLE. last_grant register resets to I.
- IDLE: I pending only -> SERVE_I. D pending only (read or write) -> SERVE_D. Both pending -> grant the side not equal to last_grant. Neither -> stay.
- On the grant edge, the arbiter captures address, op (read/write), and wdata (D only) into output registers. last_grant is updated to the winner.
- SERVE_x: outputs hold the captured values. Stays until arbi_l2_resp. On resp, returns to IDLE and clears arbi_l2_read/write.
- Responses: x_resp = arbi_l2_resp && state==SERVE_x. Both rdata outputs are driven by arbi_l2_rdata directly (combinational). A requester must sample rdata only when its resp is high.
- D with read and write both high: write wins. A bench assertion flags this case as a protocol violation.
- arbi_l2_resp in IDLE is ignored and not forwarded.
- Requester drops its request mid-service: the transaction still completes and resp still pulses. Captured values are unaffected.
- Reset mid-transaction: immediate return to IDLE. All registered outputs go to 0 and last_grant goes to I. Any late L2 resp is then ignored.

## Timing
- Reset values: arbi_l2_read=0, arbi_l2_write=0, arbi_l2_address=0, arbi_l2_wdata=0. l1i/l1d resp=0. rdata outputs follow arbi_l2_rdata.
- Request first high in cycle N (IDLE): state is SERVE_x in N+1, and downstream read/write are high from N+1.
- arbi_l2_resp high in cycle M: requester resp high in M (same cycle). IDLE in M+1 with downstream strobes low.
- Back-to-back: the other requester, still pending in M+1, is re-arbitrated in IDLE and is in SERVE from M+2. Minimum gap is 1 idle cycle between downstream transactions.
- The arbiter adds 1 cycle of request latency and 0 cycles of response latency.
- Requesters keep their request high until they see resp. They must drop it in the cycle after resp, so a request in M+1 counts as a new request.

## Structure
- Shared package cache_arbiter_pkg:
  - typedef enum state_t {IDLE, SERVE_I, SERVE_D}
  - typedef enum grant_t {GRANT_I, GRANT_D}
  - localparams ADDR_W and LINE_W, shared with the L1/L2 caches
- Sub-module cache_arbiter_control holds the FSM and last_grant, and outputs grant/capture/clear strobes.
- The top level holds the output capture registers and the resp/rdata routing.

## Test plan
- I read 0x0000_1000 alone, L2 resp after 5 cycles -> arbi_l2_read high N+1..N+6, address 0x1000. l1i_arbi_resp pulses once with rdata. l1d_arbi_resp stays 0.
- D write 0x0000_2000 with wdata 0xA5 repeated -> arbi_l2_write high, wdata captured, read=0. l1d_arbi_resp pulses on L2 resp.
- I and D assert in the same cycle after reset -> D served first (last_grant=I). I is served starting 2 cycles after D's resp. A second tie afterwards goes to D again, since last_grant is then I.
- Requester changes its address during SERVE -> arbi_l2_address keeps the captured value until resp.
- Reset asserted in SERVE_D, then L2 resp arrives -> outputs 0 immediately. No resp is forwarded, and the next tie is granted to D.
- arbi_l2_resp pulsed while in IDLE -> no upstream resp and no state change.
